// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver (and its transmitter counterpart):
//   - uart_state_t : framing state machine encoding
//   - legal parameter ranges for data width, oversample factor, stop bits
//   - cnt_width()  : clog2-based counter width helper (never below 1 bit)
//   - rx_params_legal() : elaboration-time parameter sanity check
// Optional feature macro used by the receiver: UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK
  } uart_state_t;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_STOP_BITS  = 1;

  localparam int DATA_BITS_MIN  = 5;
  localparam int DATA_BITS_MAX  = 9;
  localparam int OVERSAMPLE_MIN = 4;
  localparam int OVERSAMPLE_MAX = 32;
  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;

  // Width of a counter that must hold 0..n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit rx_params_legal(input int data_bits,
                                         input int oversample,
                                         input int stop_bits);
    return (data_bits  >= DATA_BITS_MIN)  && (data_bits  <= DATA_BITS_MAX)  &&
           (oversample >= OVERSAMPLE_MIN) && (oversample <= OVERSAMPLE_MAX) &&
           ((oversample % 2) == 0) &&
           (stop_bits  >= STOP_BITS_MIN)  && (stop_bits  <= STOP_BITS_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_framed_if.sv
// -----------------------------------------------------------------------------
// uart_rx_framed_if
// Groups the receiver's line-side inputs and receive-path outputs.
//   RX, TICK, PARITY_ODD              : driven by the master (pad / baud side)
//   DOUT, VALID, FRAME_ERR,
//   PARITY_ERR, BUSY                  : driven by the slave (the receiver)
// DATA_BITS must match the receiver instance it is connected to.
// -----------------------------------------------------------------------------
interface uart_rx_framed_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);
  logic                 RX;
  logic                 TICK;
  logic                 PARITY_ODD;
  logic [DATA_BITS-1:0] DOUT;
  logic                 VALID;
  logic                 FRAME_ERR;
  logic                 PARITY_ERR;
  logic                 BUSY;

  modport master (
    output RX, TICK, PARITY_ODD,
    input  DOUT, VALID, FRAME_ERR, PARITY_ERR, BUSY
  );

  modport slave (
    input  RX, TICK, PARITY_ODD,
    output DOUT, VALID, FRAME_ERR, PARITY_ERR, BUSY
  );
endinterface

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous pad input.
//   clk       : destination clock
//   srst      : synchronous active-high reset, both flops load RESET_VAL
//   d         : asynchronous input
//   q         : synchronised output (2 clk latency)
// -----------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/uart_rx_framed.sv
// -----------------------------------------------------------------------------
// uart_rx_framed
// Oversampling UART receiver with configurable data width, oversample factor
// and stop-bit count, false-start rejection and frame/parity error reporting.
// Ports:
//   CLOCK : system clock, rising edge
//   RESET : synchronous active-high reset
//   bus   : uart_rx_framed_if.slave
//           in : RX (async line, idle high), TICK (oversample strobe),
//                PARITY_ODD (1 = odd parity, latched at start qualification)
//           out: DOUT, VALID (1-cycle strobe), FRAME_ERR, PARITY_ERR, BUSY
// Optional feature: define UART_RX_PARITY_EN to expect one parity bit after
// the data bits. Without it PARITY_ERR is tied 0 and PARITY_ODD is unused.
// -----------------------------------------------------------------------------
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int STOP_BITS  = DEF_STOP_BITS
) (
  input logic            CLOCK,
  input logic            RESET,
  uart_rx_framed_if.slave bus
);
  localparam int SW = cnt_width(OVERSAMPLE);
  localparam int NW = cnt_width(DATA_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  if (!rx_params_legal(DATA_BITS, OVERSAMPLE, STOP_BITS)) begin : g_bad_params
    $error("uart_rx_framed: illegal DATA_BITS/OVERSAMPLE/STOP_BITS");
  end

  logic rxs;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (CLOCK),
    .srst (RESET),
    .d    (bus.RX),
    .q    (rxs)
  );

  uart_state_t          state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 stop2_q, stop2_d;   // first of two stop bits already sampled
  logic                 stop1_q, stop1_d;   // value of the first stop bit
  logic                 rxs_prev_q, rxs_prev_d;
  logic                 first_stop;
  logic                 start_edge;
  uart_state_t          after_data;

`ifdef UART_RX_PARITY_EN
  logic par_odd_q, par_odd_d;
  logic perr_pend_q, perr_pend_d;
  logic perr_q, perr_d;
  assign after_data = PARITY;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = bus.PARITY_ODD;
  assign after_data = STOP;
`endif

  // A frame needs a real falling edge: rxs_prev resets low so a line that is
  // already low when reset releases (e.g. reset mid-frame) cannot start one.
  assign start_edge = rxs_prev_q & ~rxs;

  // With two stop bits the framing verdict comes from the stored first bit.
  assign first_stop = (STOP_BITS == 2) ? stop1_q : rxs;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    dout_d     = dout_q;
    valid_d    = 1'b0;
    ferr_d     = ferr_q;
    stop2_d    = stop2_q;
    stop1_d    = stop1_q;
    rxs_prev_d = rxs;
`ifdef UART_RX_PARITY_EN
    par_odd_d   = par_odd_q;
    perr_pend_d = perr_pend_q;
    perr_d      = perr_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (bus.TICK) begin
          if (s_q == S_MID) begin
            if (rxs) begin
              state_d = IDLE;        // glitch shorter than half a bit
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
`ifdef UART_RX_PARITY_EN
              par_odd_d = bus.PARITY_ODD;
`endif
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (bus.TICK) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rxs, b_q[DATA_BITS-1:1]};
            if (n_q == N_LAST) begin
              state_d = after_data;
              stop2_d = 1'b0;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.TICK) begin
          if (s_q == S_LAST) begin
            s_d         = '0;
            perr_pend_d = ((^b_q) ^ rxs) != par_odd_q;
            state_d     = STOP;
            stop2_d     = 1'b0;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (bus.TICK) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            if ((STOP_BITS == 2) && !stop2_q) begin
              stop2_d = 1'b1;
              stop1_d = rxs;
            end else begin
              // Final stop sample is mid-bit, so a following start edge
              // right at the end of the stop bit is still caught.
              valid_d = 1'b1;
              dout_d  = b_q;
              ferr_d  = ~first_stop;
`ifdef UART_RX_PARITY_EN
              perr_d  = perr_pend_q;
`endif
              state_d = first_stop ? IDLE : BRK;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      BRK: begin
        // Hold off until the line returns high so a break yields one frame.
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      stop2_q    <= 1'b0;
      stop1_q    <= 1'b0;
      rxs_prev_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_odd_q   <= 1'b0;
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      stop2_q    <= stop2_d;
      stop1_q    <= stop1_d;
      rxs_prev_q <= rxs_prev_d;
`ifdef UART_RX_PARITY_EN
      par_odd_q   <= par_odd_d;
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign bus.DOUT      = dout_q;
  assign bus.VALID     = valid_q;
  assign bus.FRAME_ERR = ferr_q;
  assign bus.BUSY      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.PARITY_ERR = perr_q;
`else
  assign bus.PARITY_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_framed.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_framed
// Two receivers: u0 (8 data, x16, 1 stop) and u1 (7 data, x8, 2 stops).
// Each test task queues the frames it expects, drives the line, and checks
// counts/levels; per-receiver monitors pop the queue on every VALID.
// -----------------------------------------------------------------------------
module tb_uart_rx_framed;
  localparam int TDIV = 4;
  localparam int OS0  = 16;
  localparam int OS1  = 8;
  localparam int BP0  = OS0 * TDIV;
  localparam int BP1  = OS1 * TDIV;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_framed_if #(.DATA_BITS(8)) if0 ();
  uart_rx_framed_if #(.DATA_BITS(7)) if1 ();

  uart_rx_framed #(.DATA_BITS(8), .OVERSAMPLE(OS0), .STOP_BITS(1)) u0 (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (if0)
  );

  uart_rx_framed #(.DATA_BITS(7), .OVERSAMPLE(OS1), .STOP_BITS(2)) u1 (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (if1)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_cnt0 = 0;
  int valid_cnt1 = 0;
  int busy_cnt0 = 0;
  int last_v1 = 0;
  int prev_v1 = 0;

  function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    return e;
  endfunction

  initial begin : tick_gen
    int c;
    c = 0;
    if0.TICK = 1'b0;
    if1.TICK = 1'b0;
    forever begin
      @(negedge clk);
      if0.TICK = (c == TDIV - 1);
      if1.TICK = (c == TDIV - 1);
      c = (c + 1) % TDIV;
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    cyc++;
    if (if0.BUSY) busy_cnt0++;
    if (if0.VALID) begin
      valid_cnt0++;
      n_cmp++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL u0_unexpected_valid dout=%h fe=%b", if0.DOUT, if0.FRAME_ERR);
      end else begin
        e = q0.pop_front();
        if (if0.DOUT !== e.d) begin
          n_err++;
          $display("FAIL u0_dout got=%h exp=%h", if0.DOUT, e.d);
        end
        n_cmp++;
        if (if0.FRAME_ERR !== e.fe) begin
          n_err++;
          $display("FAIL u0_frame_err got=%b exp=%b", if0.FRAME_ERR, e.fe);
        end
        n_cmp++;
        if (if0.PARITY_ERR !== e.pe) begin
          n_err++;
          $display("FAIL u0_parity_err got=%b exp=%b", if0.PARITY_ERR, e.pe);
        end
        $display("u0 frame dout=%h fe=%b pe=%b", if0.DOUT, if0.FRAME_ERR, if0.PARITY_ERR);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (if1.VALID) begin
      valid_cnt1++;
      prev_v1 = last_v1;
      last_v1 = cyc;
      n_cmp++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL u1_unexpected_valid dout=%h", if1.DOUT);
      end else begin
        e = q1.pop_front();
        if (if1.DOUT !== e.d[6:0]) begin
          n_err++;
          $display("FAIL u1_dout got=%h exp=%h", if1.DOUT, e.d[6:0]);
        end
        n_cmp++;
        if (if1.FRAME_ERR !== e.fe) begin
          n_err++;
          $display("FAIL u1_frame_err got=%b exp=%b", if1.FRAME_ERR, e.fe);
        end
        $display("u1 frame dout=%h fe=%b pe=%b", if1.DOUT, if1.FRAME_ERR, if1.PARITY_ERR);
      end
    end
  end

  // Drive one u0 frame: start, 8 data LSB first, [parity], stop.
  task automatic send0(input logic [7:0] d, input logic stop, input logic par_flip);
    logic [11:0] fr;
    fr      = '1;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    if (PB == 1) begin
      fr[9]  = (^d) ^ if0.PARITY_ODD ^ par_flip;
      fr[10] = stop;
    end else begin
      fr[9] = stop;
    end
    for (int i = 0; i < 10 + PB; i++) begin
      if0.RX = fr[i];
      repeat (BP0) @(negedge clk);
    end
  endtask

  // Drive one u1 frame: start, 7 data, [parity], two high stop bits.
  task automatic send1(input logic [6:0] d);
    logic [11:0] fr;
    fr      = '1;
    fr[0]   = 1'b0;
    fr[7:1] = d;
    if (PB == 1) fr[8] = (^d) ^ if1.PARITY_ODD;
    for (int i = 0; i < 10 + PB; i++) begin
      if1.RX = fr[i];
      repeat (BP1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if0.RX = 1'b1;
    if1.RX = 1'b1;
    if0.PARITY_ODD = 1'b0;
    if1.PARITY_ODD = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (if0.DOUT !== 8'h00) begin n_err++; $display("FAIL reset_dout got=%h exp=00", if0.DOUT); end
    n_cmp++; if (if0.VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", if0.VALID); end
    n_cmp++; if (if0.FRAME_ERR !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", if0.FRAME_ERR); end
    n_cmp++; if (if0.PARITY_ERR !== 1'b0) begin n_err++; $display("FAIL reset_perr got=%b exp=0", if0.PARITY_ERR); end
    n_cmp++; if (if0.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", if0.BUSY); end
    n_cmp++; if (if1.BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got=%b exp=0", if1.BUSY); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int v0, b0, busy;
    v0 = valid_cnt0;
    b0 = busy_cnt0;
    q0.push_back(mk(8'hA5, 1'b0, 1'b0));
    send0(8'hA5, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    busy = busy_cnt0 - b0;
    n_cmp++; if (valid_cnt0 - v0 !== 1) begin n_err++; $display("FAIL basic_valid_count got=%0d exp=1", valid_cnt0 - v0); end
    n_cmp++;
    if (busy < (9 + PB) * BP0 + BP0 / 2 - BP0 / 4 || busy > (9 + PB) * BP0 + BP0 / 2 + BP0 / 4) begin
      n_err++;
      $display("FAIL basic_busy_len got=%0d exp=%0d+-%0d", busy, (9 + PB) * BP0 + BP0 / 2, BP0 / 4);
    end
    n_cmp++; if (if0.BUSY !== 1'b0) begin n_err++; $display("FAIL basic_busy_end got=%b exp=0", if0.BUSY); end
    $display("test_basic busy_cycles=%0d", busy);
  endtask

  task automatic test_false_start();
    int v0, b0;
    v0 = valid_cnt0;
    b0 = busy_cnt0;
    if0.RX = 1'b0;
    repeat (5 * TDIV) @(negedge clk);
    if0.RX = 1'b1;
    repeat (2 * BP0) @(negedge clk);
    n_cmp++; if (valid_cnt0 - v0 !== 0) begin n_err++; $display("FAIL fs_no_valid got=%0d exp=0", valid_cnt0 - v0); end
    n_cmp++;
    if (busy_cnt0 - b0 < 1 || busy_cnt0 - b0 > BP0 / 2 + 2 * TDIV) begin
      n_err++;
      $display("FAIL fs_busy_pulse got=%0d exp=1..%0d", busy_cnt0 - b0, BP0 / 2 + 2 * TDIV);
    end
    n_cmp++; if (if0.BUSY !== 1'b0) begin n_err++; $display("FAIL fs_busy_end got=%b exp=0", if0.BUSY); end
    n_cmp++; if (if0.DOUT !== 8'hA5) begin n_err++; $display("FAIL fs_dout_hold got=%h exp=a5", if0.DOUT); end
    q0.push_back(mk(8'h3C, 1'b0, 1'b0));
    send0(8'h3C, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    n_cmp++; if (valid_cnt0 - v0 !== 1) begin n_err++; $display("FAIL fs_next_frame got=%0d exp=1", valid_cnt0 - v0); end
    $display("test_false_start done");
  endtask

  task automatic test_break();
    int v0;
    v0 = valid_cnt0;
    q0.push_back(mk(8'h55, 1'b1, 1'b0));
    send0(8'h55, 1'b0, 1'b0);
    repeat (3 * BP0) @(negedge clk);
    n_cmp++; if (if0.BUSY !== 1'b1) begin n_err++; $display("FAIL brk_busy_held got=%b exp=1", if0.BUSY); end
    n_cmp++; if (valid_cnt0 - v0 !== 1) begin n_err++; $display("FAIL brk_one_valid got=%0d exp=1", valid_cnt0 - v0); end
    if0.RX = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++; if (if0.BUSY !== 1'b0) begin n_err++; $display("FAIL brk_exit got=%b exp=0", if0.BUSY); end
    repeat (2 * BP0) @(negedge clk);
    n_cmp++; if (valid_cnt0 - v0 !== 1) begin n_err++; $display("FAIL brk_no_repeat got=%0d exp=1", valid_cnt0 - v0); end
    n_cmp++; if (if0.FRAME_ERR !== 1'b1) begin n_err++; $display("FAIL brk_ferr_hold got=%b exp=1", if0.FRAME_ERR); end
    $display("test_break done");
  endtask

  task automatic test_parity();
    int v0;
    v0 = valid_cnt0;
    if0.PARITY_ODD = 1'b0;
    q0.push_back(mk(8'h07, 1'b0, 1'b0));
    send0(8'h07, 1'b1, 1'b0);
`ifdef UART_RX_PARITY_EN
    q0.push_back(mk(8'h07, 1'b0, 1'b1));
    send0(8'h07, 1'b1, 1'b1);
`else
    q0.push_back(mk(8'h06, 1'b0, 1'b0));
    send0(8'h06, 1'b1, 1'b0);
`endif
    if0.PARITY_ODD = 1'b1;
    q0.push_back(mk(8'h07, 1'b0, 1'b0));
    send0(8'h07, 1'b1, 1'b0);
    if0.PARITY_ODD = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (valid_cnt0 - v0 !== 3) begin n_err++; $display("FAIL parity_count got=%0d exp=3", valid_cnt0 - v0); end
    $display("test_parity done");
  endtask

  task automatic test_back_to_back();
    int v1, gap;
    v1 = valid_cnt1;
    q1.push_back(mk(8'h41, 1'b0, 1'b0));
    q1.push_back(mk(8'h7F, 1'b0, 1'b0));
    send1(7'h41);
    send1(7'h7F);
    repeat (20) @(negedge clk);
    gap = last_v1 - prev_v1;
    n_cmp++; if (valid_cnt1 - v1 !== 2) begin n_err++; $display("FAIL b2b_count got=%0d exp=2", valid_cnt1 - v1); end
    n_cmp++;
    if (gap < (10 + PB) * BP1 - TDIV || gap > (10 + PB) * BP1 + TDIV) begin
      n_err++;
      $display("FAIL b2b_spacing got=%0d exp=%0d", gap, (10 + PB) * BP1);
    end
    $display("test_back_to_back spacing=%0d", gap);
  endtask

  task automatic test_reset_mid();
    int v0;
    v0 = valid_cnt0;
    if0.RX = 1'b0;
    repeat (BP0) @(negedge clk);
    if0.RX = 1'b1;
    repeat (3 * BP0 + BP0 / 2) @(negedge clk);
    n_cmp++; if (if0.BUSY !== 1'b1) begin n_err++; $display("FAIL rmid_in_frame got=%b exp=1", if0.BUSY); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (if0.DOUT !== 8'h00) begin n_err++; $display("FAIL rmid_dout got=%h exp=00", if0.DOUT); end
    n_cmp++; if (if0.BUSY !== 1'b0) begin n_err++; $display("FAIL rmid_busy got=%b exp=0", if0.BUSY); end
    n_cmp++; if (if0.VALID !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%b exp=0", if0.VALID); end
    n_cmp++; if (if0.FRAME_ERR !== 1'b0) begin n_err++; $display("FAIL rmid_ferr got=%b exp=0", if0.FRAME_ERR); end
    rst = 1'b0;
    repeat (8 * BP0) @(negedge clk);
    n_cmp++; if (valid_cnt0 - v0 !== 0) begin n_err++; $display("FAIL rmid_no_valid got=%0d exp=0", valid_cnt0 - v0); end
    q0.push_back(mk(8'h12, 1'b0, 1'b0));
    send0(8'h12, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    n_cmp++; if (valid_cnt0 - v0 !== 1) begin n_err++; $display("FAIL rmid_next_frame got=%0d exp=1", valid_cnt0 - v0); end
    $display("test_reset_mid done");
  endtask

  initial begin
    if0.RX = 1'b1;
    if1.RX = 1'b1;
    if0.PARITY_ODD = 1'b0;
    if1.PARITY_ODD = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_false_start();
    test_break();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (q0.size() != 0) begin n_err++; $display("FAIL u0_queue_left got=%0d exp=0", q0.size()); end
    n_cmp++; if (q1.size() != 0) begin n_err++; $display("FAIL u1_queue_left got=%0d exp=0", q1.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
